// File: rtl/stack_exec_if.sv
// Command and stack port bundle for the stack operation executor.
// Command handshake: the front-end holds cmd_valid/cmd_op; a command transfers on
// a rising clk where cmd_valid && cmd_ready, and cmd_op is only looked at on that edge.
interface stack_exec_if;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic        cmd_ready;
  logic [31:0] stack_top;
  logic [9:0]  stack_size;
  logic        stack_push;
  logic        stack_pop;
  logic [31:0] stack_in;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  modport slave (
    input  cmd_valid, cmd_op, stack_top, stack_size,
    output cmd_ready, stack_push, stack_pop, stack_in, done, err, err_code
  );

  modport master (
    output cmd_valid, cmd_op, stack_top, stack_size,
    input  cmd_ready, stack_push, stack_pop, stack_in, done, err, err_code
  );
endinterface

// File: rtl/stack_exec.sv
// Executes one calculator opcode as a paced sequence of pop/push strobes on the stack,
// with a 32-bit ALU and a bit-serial restoring divider for DIV/MOD.
module stack_exec #(
  parameter int DEPTH      = 1023,
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  stack_exec_if.slave      bus,
  output logic [3:0]       dbg_state_o
);

  localparam int         CW      = $clog2(DIV_CYCLES + 1);
  localparam logic [9:0] DEPTH_L = 10'(DEPTH);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_MOD  = 3'd4;
  localparam logic [2:0] OP_POP  = 3'd5;
  localparam logic [2:0] OP_DUP  = 3'd6;
  localparam logic [2:0] OP_SWAP = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_POP1, S_WAIT1, S_POP2, S_EXEC, S_PUSH, S_GAP, S_PUSHA, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   rem_q, rem_d, quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          push_q, push_d, pop_q, pop_d;
  logic          done_q, done_d, err_q, err_d;
  logic [31:0]   stack_in_q, stack_in_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          is_div;
  logic [1:0]    chk_code;
  logic [32:0]   rem_sh;
  logic [31:0]   rem_nx, quo_nx, res;

  assign is_div = (op_q == OP_DIV) || (op_q == OP_MOD);

  // Accept-time checks, evaluated on the live stack view; first failing one wins.
  always_comb begin
    logic under;
    under = 1'b0;
    if (bus.cmd_op == OP_POP || bus.cmd_op == OP_DUP) under = (bus.stack_size == 10'd0);
    else                                              under = (bus.stack_size < 10'd2);
    if (under)                                                   chk_code = 2'd1;
    else if (bus.cmd_op == OP_DUP && bus.stack_size >= DEPTH_L)  chk_code = 2'd2;
    else if ((bus.cmd_op == OP_DIV || bus.cmd_op == OP_MOD) && bus.stack_top == 32'd0)
                                                                 chk_code = 2'd3;
    else                                                         chk_code = 2'd0;
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    rem_nx = rem_sh[31:0];
    quo_nx = {quo_q[30:0], 1'b0};
    if (rem_sh >= {1'b0, b_q}) begin
      rem_nx = 32'(rem_sh - {1'b0, b_q});
      quo_nx = {quo_q[30:0], 1'b1};
    end
  end

  always_comb begin
    res = b_q;
    case (op_q)
      OP_ADD:  res = a_q + b_q;
      OP_SUB:  res = a_q - b_q;
      OP_MUL:  res = a_q * b_q;
      OP_DIV:  res = quo_nx;
      OP_MOD:  res = rem_nx;
      default: res = b_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    stack_in_d = stack_in_q;
    err_code_d = err_code_q;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          op_d       = bus.cmd_op;
          b_d        = bus.stack_top;
          err_code_d = chk_code;
          if (chk_code != 2'd0) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (bus.cmd_op == OP_DUP) begin
            state_d    = S_PUSH;
            stack_in_d = bus.stack_top;
          end else begin
            state_d = S_POP1;
          end
        end
      end
      S_POP1:  state_d = (op_q == OP_POP) ? S_DONE : S_WAIT1;
      S_WAIT1: state_d = S_POP2;
      S_POP2: begin
        a_d     = bus.stack_top;
        rem_d   = 32'd0;
        quo_d   = bus.stack_top;
        cnt_d   = CW'(DIV_CYCLES - 1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // The final divider step feeds straight into the push register.
        if (is_div && cnt_q != '0) begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q - CW'(1);
        end else begin
          stack_in_d = res;
          state_d    = S_PUSH;
        end
      end
      S_PUSH:  state_d = (op_q == OP_SWAP) ? S_GAP : S_DONE;
      S_GAP: begin
        stack_in_d = a_q;
        state_d    = S_PUSHA;
      end
      S_PUSHA: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    push_d  = (state_d == S_PUSH) || (state_d == S_PUSHA);
    pop_d   = (state_d == S_POP1) || (state_d == S_POP2);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      stack_in_q <= '0;
      err_code_q <= '0;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      done_q     <= done_d;
      err_q      <= err_d;
      stack_in_q <= stack_in_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.stack_push = push_q;
  assign bus.stack_pop  = pop_q;
  assign bus.stack_in   = stack_in_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_stack_exec.sv
// Directed bench for stack_exec: a behavioural stack answers the strobes and each
// opcode's strobe timing, pushed values, completion and error reporting are checked.
module tb_stack_exec;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_exec_if bus();
  logic [3:0] dbg_state;

  stack_exec #(.DEPTH(1023), .DIV_CYCLES(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural stack: strobes sampled on the edge, new view visible the next cycle.
  logic [31:0] mem [0:1023];
  logic [9:0]  sp;
  logic        pre_req = 1'b0;
  logic [9:0]  pre_n   = '0;
  logic [31:0] pre_top = '0;
  logic [31:0] pre_sec = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) sp <= '0;
    else if (pre_req) begin
      sp <= pre_n;
      if (pre_n >= 10'd1) mem[pre_n - 10'd1] <= pre_top;
      if (pre_n >= 10'd2) mem[pre_n - 10'd2] <= pre_sec;
    end else if (bus.stack_push) begin
      mem[sp] <= bus.stack_in;
      sp      <= sp + 10'd1;
    end else if (bus.stack_pop) begin
      sp <= sp - 10'd1;
    end
  end

  assign bus.stack_top  = (sp == 10'd0) ? 32'd0 : mem[sp - 10'd1];
  assign bus.stack_size = sp;

  // Strobe contract monitor: no push+pop together, idle gap between strobes, no done with a strobe.
  int   viol = 0;
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.stack_push && bus.stack_pop) viol++;
      if ((bus.stack_push || bus.stack_pop) && prev_strobe) viol++;
      if (bus.done && (bus.stack_push || bus.stack_pop)) viol++;
    end
    prev_strobe <= !reset && (bus.stack_push || bus.stack_pop);
  end

  int o_npop, o_pop1, o_pop2, o_npush, o_p1c, o_p2c, o_done, o_err, o_code;
  logic [31:0] o_p1v, o_p2v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_stack(input int n, input logic [31:0] sec, input logic [31:0] top);
    @(negedge clk);
    pre_req = 1'b1;
    pre_n   = 10'(n);
    pre_sec = sec;
    pre_top = top;
    @(negedge clk);
    pre_req = 1'b0;
  endtask

  // Offers one command, then records strobes relative to the accept edge (cycle 0).
  task automatic run_op(input logic [2:0] op, input string name);
    bit fin;
    @(negedge clk);
    chk({name, " ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom_range(0, 7));
    o_npop = 0; o_pop1 = 0; o_pop2 = 0; o_npush = 0; o_p1c = 0; o_p2c = 0;
    o_p1v = '0; o_p2v = '0; o_done = 0; o_err = 0; o_code = 0;
    fin = 1'b0;
    for (int k = 1; k <= 60 && !fin; k++) begin
      if (bus.stack_pop) begin
        o_npop++;
        if (o_npop == 1) o_pop1 = k; else o_pop2 = k;
      end
      if (bus.stack_push) begin
        o_npush++;
        if (o_npush == 1) begin o_p1c = k; o_p1v = bus.stack_in; end
        else begin o_p2c = k; o_p2v = bus.stack_in; end
      end
      if (bus.done) begin
        o_done = k;
        o_err  = int'(bus.err);
        o_code = int'(bus.err_code);
        fin    = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk({name, " finished"}, 32'(fin), 32'd1);
  endtask

  task automatic expect_op(input string name, input int npop, input int pop1, input int pop2,
                           input int npush, input int p1c, input logic [31:0] p1v,
                           input int p2c, input logic [31:0] p2v,
                           input int done_c, input int err_e, input int code);
    chk({name, " pops"}, 32'(o_npop), 32'(npop));
    if (npop > 0) chk({name, " pop1 cycle"}, 32'(o_pop1), 32'(pop1));
    if (npop > 1) chk({name, " pop2 cycle"}, 32'(o_pop2), 32'(pop2));
    chk({name, " pushes"}, 32'(o_npush), 32'(npush));
    if (npush > 0) begin
      chk({name, " push1 cycle"}, 32'(o_p1c), 32'(p1c));
      chk({name, " push1 value"}, o_p1v, p1v);
    end
    if (npush > 1) begin
      chk({name, " push2 cycle"}, 32'(o_p2c), 32'(p2c));
      chk({name, " push2 value"}, o_p2v, p2v);
    end
    chk({name, " done cycle"}, 32'(o_done), 32'(done_c));
    chk({name, " err"}, 32'(o_err), 32'(err_e));
    chk({name, " err_code"}, 32'(o_code), 32'(code));
  endtask

  initial begin
    int strobes;
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    repeat (2) @(negedge clk);
    chk("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("reset push", 32'(bus.stack_push), 32'd0);
    chk("reset pop", 32'(bus.stack_pop), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset err", 32'(bus.err), 32'd0);
    chk("reset err_code", 32'(bus.err_code), 32'd0);
    chk("reset stack_in", bus.stack_in, 32'd0);
    chk("reset state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready after reset", 32'(bus.cmd_ready), 32'd1);

    set_stack(2, 32'd7, 32'd5);
    run_op(3'd0, "add");
    expect_op("add", 2, 1, 3, 1, 5, 32'd12, 0, 32'd0, 6, 0, 0);
    @(negedge clk);
    chk("add size", 32'(sp), 32'd1);
    chk("add top", bus.stack_top, 32'd12);

    set_stack(2, 32'd3, 32'd5);
    run_op(3'd1, "sub");
    expect_op("sub", 2, 1, 3, 1, 5, 32'hFFFF_FFFE, 0, 32'd0, 6, 0, 0);

    set_stack(2, 32'h0001_0000, 32'h0001_0000);
    run_op(3'd2, "mul");
    expect_op("mul", 2, 1, 3, 1, 5, 32'h0000_0000, 0, 32'd0, 6, 0, 0);

    set_stack(2, 32'd100, 32'd7);
    run_op(3'd3, "div");
    expect_op("div", 2, 1, 3, 1, 36, 32'd14, 0, 32'd0, 37, 0, 0);

    set_stack(2, 32'd100, 32'd7);
    run_op(3'd4, "mod");
    expect_op("mod", 2, 1, 3, 1, 36, 32'd2, 0, 32'd0, 37, 0, 0);

    set_stack(2, 32'd9, 32'd0);
    run_op(3'd3, "div0");
    expect_op("div0", 0, 0, 0, 0, 0, 32'd0, 0, 32'd0, 1, 1, 3);
    repeat (2) @(negedge clk);
    chk("div0 size", 32'(sp), 32'd2);
    chk("div0 top", bus.stack_top, 32'd0);
    chk("div0 second", mem[sp - 10'd2], 32'd9);
    chk("div0 err_code held", 32'(bus.err_code), 32'd3);
    chk("div0 done low after", 32'(bus.done), 32'd0);
    chk("div0 err low after", 32'(bus.err), 32'd0);

    set_stack(1, 32'd0, 32'd4);
    run_op(3'd0, "add size1");
    expect_op("add size1", 0, 0, 0, 0, 0, 32'd0, 0, 32'd0, 1, 1, 1);
    @(negedge clk);
    chk("add size1 size", 32'(sp), 32'd1);

    set_stack(0, 32'd0, 32'd0);
    run_op(3'd5, "pop empty");
    expect_op("pop empty", 0, 0, 0, 0, 0, 32'd0, 0, 32'd0, 1, 1, 1);

    set_stack(1023, 32'd0, 32'd6);
    run_op(3'd6, "dup full");
    expect_op("dup full", 0, 0, 0, 0, 0, 32'd0, 0, 32'd0, 1, 1, 2);
    @(negedge clk);
    chk("dup full size", 32'(sp), 32'd1023);

    set_stack(2, 32'd1, 32'd2);
    run_op(3'd7, "swap");
    expect_op("swap", 2, 1, 3, 2, 5, 32'd2, 7, 32'd1, 8, 0, 0);
    @(negedge clk);
    chk("swap size", 32'(sp), 32'd2);
    chk("swap top", bus.stack_top, 32'd1);
    chk("swap second", mem[sp - 10'd2], 32'd2);

    set_stack(2, 32'd4, 32'd9);
    run_op(3'd5, "pop");
    expect_op("pop", 1, 1, 0, 0, 0, 32'd0, 0, 32'd0, 2, 0, 0);
    @(negedge clk);
    chk("pop size", 32'(sp), 32'd1);
    chk("pop top", bus.stack_top, 32'd4);

    set_stack(1, 32'd0, 32'd9);
    run_op(3'd6, "dup");
    expect_op("dup", 0, 0, 0, 1, 1, 32'd9, 0, 32'd0, 2, 0, 0);
    @(negedge clk);
    chk("dup size", 32'(sp), 32'd2);
    chk("dup top", bus.stack_top, 32'd9);

    // Reset in cycle 4 of a DIV: outputs clear at once, nothing resumes afterwards.
    set_stack(2, 32'd100, 32'd7);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd3;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("midreset push", 32'(bus.stack_push), 32'd0);
    chk("midreset pop", 32'(bus.stack_pop), 32'd0);
    chk("midreset done", 32'(bus.done), 32'd0);
    chk("midreset err", 32'(bus.err), 32'd0);
    chk("midreset stack_in", bus.stack_in, 32'd0);
    chk("midreset state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset ready after release", 32'(bus.cmd_ready), 32'd1);
    strobes = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.stack_push || bus.stack_pop || bus.done) strobes++;
      @(negedge clk);
    end
    chk("midreset no activity", 32'(strobes), 32'd0);

    chk("strobe contract", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stack_exec.md
Name: stack_exec

Overview:
Operation executor sitting between the calculator front-end FSM and the stack.
- Accepts one opcode per handshake from the front-end.
- Executes the opcode as a sequence of single-cycle pop/push strobes on the stack port.
- Produces a 32-bit result and reports completion or error.
- The front-end only issues commands; it never drives the stack for arithmetic.

Parameters:
DEPTH, 1023, maximum stack entries; compared against stack_size for the full check.
DIV_CYCLES, 32, iterations of the restoring divider; equals the operand width.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_op  in  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101 POP, 110 DUP, 111 SWAP
cmd_ready  out  1  high only in IDLE; command accepted on a clock edge where cmd_valid && cmd_ready
stack_top  in  32  current top-of-stack value
stack_size  in  10  current entry count
stack_push  out  1  one-cycle push strobe
stack_pop  out  1  one-cycle pop strobe
stack_in  out  32  value to push; valid while stack_push is high
done  out  1  one-cycle pulse when the command finishes (success or error)
err  out  1  high together with done when the command was rejected
err_code  out  2  0 none, 1 underflow, 2 full, 3 divide-by-zero; held until the next accept

Behaviour:
- Reset: asynchronous and immediate.
  - State goes to IDLE; all outputs go to 0 (cmd_ready goes to 1 once reset deasserts).
  - A reset mid-operation abandons the sequence; the stack is not repaired, and the front-end resets the stack simultaneously.
- Stack timing contract: the stack samples strobes at a clock edge; stack_top and stack_size are valid the following cycle.
  - Consecutive strobes are separated by at least one idle cycle.
  - stack_push and stack_pop are never high together.
- All outputs are registered.
- Accept edge (cycle 0):
  - Latch b = stack_top and the opcode.
  - Evaluate checks in priority order: underflow, full, divide-by-zero.
  - Underflow: ADD, SUB, MUL, DIV, MOD and SWAP need size >= 2; POP and DUP need size >= 1.
  - Full: DUP needs size < DEPTH.
  - Divide-by-zero: DIV and MOD with b == 0.
- Error path: in cycle 1, done = err = 1 and err_code is set; no strobes are issued; return to IDLE. The stack is unchanged.
- Binary ops (a = second entry, b = top; result = a op b), states POP1, WAIT1, POP2, EXEC, PUSH, DONE:
  - Cycle 1: pop.
  - Cycle 3: latch a = stack_top, pop.
  - Cycle 4: EXEC.
  - Cycle 5: push result.
  - Cycle 6: done.
- Arithmetic: 32-bit unsigned.
  - ADD and SUB wrap modulo 2^32.
  - MUL keeps the low 32 bits.
  - DIV gives the quotient; MOD gives the remainder.
- Divider: EXEC lasts DIV_CYCLES cycles for DIV and MOD, so push lands in cycle 36 and done in cycle 37.
- POP: pop in cycle 1, done in cycle 2.
- DUP: push b in cycle 1, done in cycle 2.
- SWAP: pop in cycle 1; latch a and pop in cycle 3; push b in cycle 5; push a in cycle 7; done in cycle 8. The new top is the old second entry.
- cmd_valid is ignored outside IDLE. cmd_op is sampled only at the accept edge.
- done is never high in the same cycle as a strobe.

Test Plan:
- Stack [7, 5] (top 5), ADD accepted -> pop in cycles 1 and 3, push of 12 in cycle 5, done in cycle 6, err = 0, size goes 2 -> 1.
- Stack [3, 5], SUB -> push 0xFFFFFFFE (wrap). Stack [0x10000, 0x10000], MUL -> push 0x00000000.
- Stack [100, 7], DIV -> push 14 in cycle 36, done in cycle 37; MOD -> push 2.
- Stack [9, 0], DIV -> done = err = 1 in cycle 1, err_code = 3, no strobes, stack unchanged.
- Underflow and full:
  - Size 1, ADD -> err_code = 1.
  - Size 0, POP -> err_code = 1.
  - Size 1023, DUP -> err_code = 2.
  - In all three, no strobes are issued.
- Stack [1, 2], SWAP -> stack [2, 1], done in cycle 8.
- Reset asserted in cycle 4 of a DIV -> all outputs 0 immediately; cmd_ready = 1 the first cycle after release; no further strobes.
